// File: rtl/ps2_host_tx_pkg.sv
// Shared encodings for the PS/2 host transmitter: FSM states, wire frame layout
// and the keyboard command bytes this host commonly sends.
package ps2_host_tx_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned BIT_W   = 4;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_INHIBIT   = 3'd1;
  localparam logic [STATE_W-1:0] ST_RTS       = 3'd2;
  localparam logic [STATE_W-1:0] ST_SHIFT     = 3'd3;
  localparam logic [STATE_W-1:0] ST_ACK       = 3'd4;
  localparam logic [STATE_W-1:0] ST_WAIT_IDLE = 3'd5;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;
  localparam logic [7:0] RSP_ACK     = 8'hFA;

  // Bits after the start bit, in wire order from bit 0 upward
  typedef struct packed {
    logic       stop;
    logic       parity;
    logic [7:0] data;
  } frame_t;

  localparam int unsigned FRAME_W = $bits(frame_t);

  // Odd parity: ones over data+parity is odd
  function automatic frame_t make_frame(input logic [7:0] data);
    frame_t f;
    f.stop   = 1'b1;
    f.parity = ~^data;
    f.data   = data;
    return f;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side handshake between the system and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic       err;

  modport master (output tx_data, output tx_start, input busy, input done, input err);
  modport slave  (input tx_data, input tx_start, output busy, output done, output err);
endinterface

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchronizer for one open-drain PS/2 line plus a falling-edge strobe.
module ps2_host_tx_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic fall_c
);

  logic meta_q;
  logic prev_q;

  // Reset to the idle-high bus level so release from reset never looks like an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      level  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line;
      level  <= meta_q;
      prev_q <= level;
    end
  end

  assign fall_c = prev_q & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits LSB
// first, odd parity, stop, then the device ACK; lines are driven open-drain.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic           clk,
  input  logic           rst,
  ps2_host_tx_if.slave   tx,
  input  logic           ps2_clk_in,
  input  logic           ps2_data_in,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [INH_W-1:0]   inh_q, inh_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d, tmo_inc_c;
  logic [BIT_W-1:0]   bit_q, bit_d;
  frame_t             frame_q, frame_d;
  logic               clk_oe_d, data_oe_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic               clk_level, clk_fall_raw_c, clk_fall_c;
  logic               data_level, data_fall_unused;
  logic               tmo_expire_c;

  ps2_host_tx_line_sync u_clk_sync (
    .clk    (clk),
    .rst    (rst),
    .line   (ps2_clk_in),
    .level  (clk_level),
    .fall_c (clk_fall_raw_c)
  );

  ps2_host_tx_line_sync u_data_sync (
    .clk    (clk),
    .rst    (rst),
    .line   (ps2_data_in),
    .level  (data_level),
    .fall_c (data_fall_unused)
  );

  // Our own inhibit pulls the clock low; never treat that as a device edge
  assign clk_fall_c   = clk_fall_raw_c & ~ps2_clk_oe;
  assign tmo_expire_c = (tmo_q >= TMO_W'(TIMEOUT_CYCLES - 1));
  assign tmo_inc_c    = (tmo_q == TMO_W'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + TMO_W'(1);

  always_comb begin
    state_d   = state_q;
    inh_d     = inh_q;
    tmo_d     = tmo_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    clk_oe_d  = ps2_clk_oe;
    data_oe_d = ps2_data_oe;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx.tx_start) begin
          state_d   = ST_INHIBIT;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          busy_d    = 1'b1;
          inh_d     = '0;
          frame_d   = make_frame(tx.tx_data);
        end
      end

      // Last inhibit cycle overlaps the start bit, so clk_oe stays high INHIBIT_CYCLES total
      ST_INHIBIT: begin
        inh_d = inh_q + INH_W'(1);
        if (inh_q >= INH_W'(INHIBIT_CYCLES - 2)) begin
          state_d   = ST_RTS;
          data_oe_d = 1'b1;
        end
      end

      ST_RTS: begin
        state_d  = ST_SHIFT;
        clk_oe_d = 1'b0;
        bit_d    = '0;
        tmo_d    = '0;
      end

      ST_SHIFT: begin
        if (tmo_expire_c) begin
          state_d   = ST_IDLE;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          busy_d    = 1'b0;
          err_d     = 1'b1;
        end else begin
          tmo_d = tmo_inc_c;
          if (clk_fall_c) begin
            data_oe_d = ~frame_q[0];
            frame_d   = frame_t'({1'b1, frame_q[FRAME_W-1:1]});
            bit_d     = bit_q + BIT_W'(1);
            if (bit_q == BIT_W'(FRAME_W - 1)) begin
              state_d = ST_ACK;
            end
          end
        end
      end

      ST_ACK: begin
        if (tmo_expire_c) begin
          state_d   = ST_IDLE;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          busy_d    = 1'b0;
          err_d     = 1'b1;
        end else begin
          tmo_d = tmo_inc_c;
          if (clk_fall_c) begin
            if (!data_level) begin
              state_d = ST_WAIT_IDLE;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              err_d   = 1'b1;
            end
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (tmo_expire_c) begin
          state_d   = ST_IDLE;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          busy_d    = 1'b0;
          err_d     = 1'b1;
        end else begin
          tmo_d = tmo_inc_c;
          if (clk_level && data_level) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      inh_q       <= '0;
      tmo_q       <= '0;
      bit_q       <= '0;
      frame_q     <= '1;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      inh_q       <= inh_d;
      tmo_q       <= tmo_d;
      bit_q       <= bit_d;
      frame_q     <= frame_d;
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign tx.busy = busy_q;
  assign tx.done = done_q;
  assign tx.err  = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on the open-drain wires, a result
// scoreboard fed at stimulus time, and a monitor that checks each done/err.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INH = 40;
  localparam int TMO = 2000;
  localparam int HP  = 25;

  localparam int M_ACK    = 0;
  localparam int M_NOACK  = 1;
  localparam int M_SILENT = 2;
  localparam int M_ABORT  = 3;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       ok;
    logic       has_rx;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } rx_t;

  logic clk = 1'b0;
  logic rst;
  logic ps2_clk_oe, ps2_data_oe;
  logic ps2_clk_in, ps2_data_in;
  logic dev_clk_lo, dev_data_lo;
  logic abort_flag;
  int   mode;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;

  exp_t exp_q[$];
  rx_t  rx_q[$];

  ps2_host_tx_if bus ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx          (bus),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  // Open-drain wired-AND of host and device
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_lo);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_lo);

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Device: clocks the frame in, samples each bit at the end of the low phase
  initial begin : device
    logic [9:0] bits;
    logic       aborted;
    dev_clk_lo  = 1'b0;
    dev_data_lo = 1'b0;
    bits        = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.busy && !ps2_clk_oe && ps2_data_oe) begin
        aborted = 1'b0;
        if (mode != M_SILENT) begin
          repeat (10) @(negedge clk);
          check("start_bit", 32'(ps2_data_in), 32'd0);
          for (int k = 0; k < 10; k++) begin
            dev_clk_lo = 1'b1;
            repeat (HP) @(negedge clk);
            bits[k] = ps2_data_in;
            if (mode == M_ABORT && k == 3) begin
              abort_flag = 1'b1;
              aborted    = 1'b1;
              break;
            end
            dev_clk_lo = 1'b0;
            repeat (HP) @(negedge clk);
          end
          if (aborted) begin
            repeat (5) @(negedge clk);
            dev_clk_lo = 1'b0;
          end else begin
            check("stop_bit", 32'(bits[9]), 32'd1);
            rx_q.push_back('{data: bits[7:0], par: bits[8]});
            if (mode != M_NOACK) dev_data_lo = 1'b1;
            repeat (HP / 2) @(negedge clk);
            dev_clk_lo = 1'b1;
            repeat (HP) @(negedge clk);
            dev_clk_lo = 1'b0;
            repeat (HP / 2) @(negedge clk);
            dev_data_lo = 1'b0;
          end
        end
        while (bus.busy) @(negedge clk);
      end
    end
  end

  // Monitor: every done/err pops one expected result
  initial begin : monitor
    exp_t e;
    rx_t  r;
    logic pend;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("pulse_width", 32'({bus.done, bus.err}), 32'd0);
        pend = 1'b0;
      end else if (!rst && (bus.done || bus.err)) begin
        pend = 1'b1;
        if (bus.done) done_cnt++;
        if (bus.err)  err_cnt++;
        check("done_err_exclusive", 32'(bus.done & bus.err), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'({bus.done, bus.err}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result_kind", 32'(bus.done), 32'(e.ok));
          if (e.has_rx) begin
            if (rx_q.size() == 0) begin
              check("rx_present", 32'(rx_q.size()), 32'd1);
            end else begin
              r = rx_q.pop_front();
              check("rx_data", 32'(r.data), 32'(e.data));
              check("rx_parity", 32'(r.par), 32'(e.par));
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic par, input logic ok,
                      input logic has_rx, input logic push);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    if (push) exp_q.push_back('{data: d, par: par, ok: ok, has_rx: has_rx});
    @(negedge clk);
    bus.tx_start = 1'b0;
    check("busy_after_accept", 32'(bus.busy & ps2_clk_oe), 32'd1);
  endtask

  task automatic measure_inhibit(output int hi, output int ov, output logic dat);
    hi = 0;
    ov = 0;
    while (ps2_clk_oe && hi < INH + 20) begin
      hi++;
      if (ps2_data_oe) ov++;
      @(negedge clk);
    end
    dat = ps2_data_oe;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : stim
    int   hi, ov, d0, e0, n;
    logic dat;
    rst          = 1'b1;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
    mode         = M_ACK;
    abort_flag   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({ps2_clk_oe, ps2_data_oe, bus.busy, bus.done, bus.err}), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Set-LED command with full handshake and inhibit timing
    d0 = done_cnt; e0 = err_cnt;
    send(CMD_SET_LED, 1'b1, 1'b1, 1'b1, 1'b1);
    measure_inhibit(hi, ov, dat);
    check("inhibit_len", 32'(hi), 32'(INH));
    check("rts_overlap", 32'(ov), 32'd1);
    check("start_before_release", 32'(dat), 32'd1);
    wait_idle();
    check("done_once", 32'(done_cnt - d0), 32'd1);
    check("no_err", 32'(err_cnt - e0), 32'd0);
    check("busy_low_after", 32'(bus.busy), 32'd0);
    repeat (100) @(negedge clk);

    // Parity 0 and parity 1 patterns
    d0 = done_cnt;
    send(8'h07, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_idle();
    repeat (100) @(negedge clk);
    send(8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_idle();
    check("done_two", 32'(done_cnt - d0), 32'd2);
    repeat (100) @(negedge clk);

    // Missing ACK
    mode = M_NOACK;
    d0 = done_cnt; e0 = err_cnt;
    send(CMD_RESET, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_idle();
    check("noack_err", 32'(err_cnt - e0), 32'd1);
    check("noack_no_done", 32'(done_cnt - d0), 32'd0);
    check("noack_lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    repeat (100) @(negedge clk);

    // Silent device: timeout measured from clock release
    mode = M_SILENT;
    e0 = err_cnt;
    send(CMD_ECHO, 1'b1, 1'b0, 1'b0, 1'b1);
    measure_inhibit(hi, ov, dat);
    n = 0;
    while (!bus.err && n < TMO + 50) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", 32'(n), 32'(TMO));
    check("timeout_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    wait_idle();
    check("timeout_err", 32'(err_cnt - e0), 32'd1);
    repeat (100) @(negedge clk);

    // Reset in the middle of a frame, then a clean frame
    mode = M_ABORT;
    send(CMD_SET_LED, 1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!abort_flag && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached", 32'(abort_flag), 32'd1);
    #2 rst = 1'b1;
    #1 check("async_release", 32'({ps2_clk_oe, ps2_data_oe, bus.busy}), 32'd0);
    repeat (3) @(negedge clk);
    rst        = 1'b0;
    abort_flag = 1'b0;
    mode       = M_ACK;
    repeat (20) @(negedge clk);
    d0 = done_cnt;
    send(CMD_RESET, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_idle();
    check("post_reset_done", 32'(done_cnt - d0), 32'd1);
    repeat (100) @(negedge clk);

    // Second start while busy is dropped
    d0 = done_cnt;
    send(8'h5A, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    bus.tx_data  = 8'hC3;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    wait_idle();
    repeat (200) @(negedge clk);
    check("single_done", 32'(done_cnt - d0), 32'd1);
    check("still_idle", 32'(bus.busy), 32'd0);
    check("exp_drained", 32'(exp_q.size()), 32'd0);
    check("rx_drained", 32'(rx_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
